// File: rtl/scmp_bus_responder.sv
// -----------------------------------------------------------------------------
// scmp_bus_responder
//
// Clocked memory/peripheral end of the SC/MP external bus. On an address
// strobe it captures the address and the {H,D,I,R} status flags carried on
// d_i[7:4]. It then serves the following read or write strobe from an
// internal RAM window, stretching the CPU cycle through hold_n for
// WAIT_STATES clocks. All outputs are registered.
//
// Parameters
//   MEM_SIZE    : RAM depth in bytes (power of two, <= 4096)
//   BASE_ADDR   : window base address, MEM_SIZE aligned
//   WAIT_STATES : hold_n low cycles per selected access (0..15)
//
// Ports
//   clk     in   CPU clock, every input sampled on the rising edge
//   rst_n   in   asynchronous active-low reset
//   addr    in   CPU address bus [11:0]
//   d_i     in   CPU data out: status on [7:4] at ads_n, write data at wr_n
//   ads_n   in   address strobe, active-low
//   rd_n    in   read strobe, active-low
//   wr_n    in   write strobe, active-low
//   d_o     out  read data to the CPU (8'hFF when idle)
//   hold_n  out  cycle extend to the CPU, active-low
//   flags   out  {H,D,I,R} latched at the last address strobe
//   sel     out  last captured address lies inside the RAM window
//
// Build option
//   SCMP_BUS_RESP_WPROT_EN : when defined, the lower half of the window is
//   read-only (boot image). Writes there still run the full hold_n sequence
//   but leave the RAM unchanged.
// -----------------------------------------------------------------------------
module scmp_bus_responder #(
  parameter int unsigned MEM_SIZE    = 128,
  parameter logic [11:0] BASE_ADDR   = 12'h000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  input  logic [7:0]  d_i,
  input  logic        ads_n,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [7:0]  d_o,
  output logic        hold_n,
  output logic [3:0]  flags,
  output logic        sel
);

  localparam int unsigned IW       = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [11:0] IDX_MASK = 12'(MEM_SIZE - 1);
  localparam bit          NO_WAIT  = (WAIT_STATES == 0);
  // Counter is loaded with WAIT_STATES-1 so that the access completes on the
  // edge where it reads zero, giving exactly WAIT_STATES low hold_n cycles.
  localparam logic [3:0]  WS_LOAD  = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    flags_q, flags_d;
  logic          sel_q, sel_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_wr_q, op_wr_d;
  logic [7:0]    d_o_q, d_o_d;
  logic          hold_n_q, hold_n_d;

  logic [7:0]    mem [MEM_SIZE];

  logic          one_strobe_s;
  logic          released_s;
  logic          wr_done_s;
  logic          wprot_s;
  logic          we_s;
  logic          win_hit_s;

  // Exactly one of rd_n/wr_n low starts an access; both low is a protocol error.
  assign one_strobe_s = rd_n ^ wr_n;
  // The strobe that started the pending access has been let go.
  assign released_s   = op_wr_q ? wr_n : rd_n;
  assign win_hit_s    = ((addr & ~IDX_MASK) == BASE_ADDR);

  // A write completes either straight from ADDR (no wait states) or on the
  // WAIT edge where the counter has run out; a new address strobe always wins.
  assign wr_done_s = ads_n &
                     (((state_q == S_ADDR) & one_strobe_s & sel_q & NO_WAIT & ~wr_n) |
                      ((state_q == S_WAIT) & ~released_s & (cnt_q == 4'd0) & op_wr_q));

`ifdef SCMP_BUS_RESP_WPROT_EN
  // Lower half of the window (index MSB clear) holds the boot image.
  assign wprot_s = ~idx_q[IW-1];
`else
  assign wprot_s = 1'b0;
`endif

  assign we_s = wr_done_s & ~wprot_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an address strobe re-captures from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!ads_n) state_d = S_ADDR;
        else        state_d = S_IDLE;
      end
      S_ADDR: begin
        if (!ads_n)                                      state_d = S_ADDR;
        else if (one_strobe_s && sel_q && !NO_WAIT)      state_d = S_WAIT;
        else if (one_strobe_s || (!rd_n && !wr_n))       state_d = S_DONE;
        else                                             state_d = S_ADDR;
      end
      S_WAIT: begin
        if (!ads_n)               state_d = S_ADDR;
        else if (released_s)      state_d = S_IDLE;
        else if (cnt_q == 4'd0)   state_d = S_DONE;
        else                      state_d = S_WAIT;
      end
      S_DONE: begin
        if (!ads_n)               state_d = S_ADDR;
        else if (rd_n && wr_n)    state_d = S_IDLE;
        else                      state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    idx_d    = idx_q;
    flags_d  = flags_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    d_o_d    = 8'hFF;
    hold_n_d = 1'b1;
    if (!ads_n) begin
      // Capture (or abort-and-recapture): drop any access in flight.
      idx_d   = addr[IW-1:0];
      flags_d = d_i[7:4];
      sel_d   = win_hit_s;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (one_strobe_s && sel_q) begin
            op_wr_d = ~wr_n;
            if (NO_WAIT) begin
              if (wr_n) d_o_d = mem[idx_q];
              else      d_o_d = 8'hFF;
            end else begin
              hold_n_d = 1'b0;
              cnt_d    = WS_LOAD;
            end
          end else begin
            hold_n_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (released_s) begin
            hold_n_d = 1'b1;
          end else if (cnt_q == 4'd0) begin
            hold_n_d = 1'b1;
            if (op_wr_q) d_o_d = 8'hFF;
            else         d_o_d = mem[idx_q];
          end else begin
            hold_n_d = 1'b0;
            cnt_d    = cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          // Read data stays on the bus until the CPU lets go of rd_n.
          if (rd_n) d_o_d = 8'hFF;
          else      d_o_d = d_o_q;
        end
        default: begin
          d_o_d = 8'hFF;
        end
      endcase
    end
  end

  // Registered outputs and captured access context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      flags_q  <= 4'b0000;
      sel_q    <= 1'b0;
      cnt_q    <= 4'd0;
      op_wr_q  <= 1'b0;
      d_o_q    <= 8'hFF;
      hold_n_q <= 1'b1;
    end else begin
      idx_q    <= idx_d;
      flags_q  <= flags_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      d_o_q    <= d_o_d;
      hold_n_q <= hold_n_d;
    end
  end

  // RAM write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we_s) mem[idx_q] <= d_i;
  end

  assign d_o    = d_o_q;
  assign hold_n = hold_n_q;
  assign flags  = flags_q;
  assign sel    = sel_q;

endmodule

// File: doc/scmp_bus_responder.md
Name: scmp_bus_responder

Overview:
- Synchronous bus responder for the SC/MP core's external bus: the memory/peripheral end of the ADS_n/RD_n/WR_n protocol the CPU initiates.
- Per cycle, captures the address and the H/D/I/R status flags at address strobe, then serves the read or write from an internal RAM window.
- Inserts programmable wait states via hold_n.
- Replaces the asynchronous board-level memory glue with a fully clocked block on the CPU clock.

Parameters:
- MEM_SIZE, 128, RAM depth in bytes; power of two, at most 4096.
- BASE_ADDR, 12'h000, window base; must be MEM_SIZE-aligned.
- WAIT_STATES, 1, hold_n low cycles per selected access; range 0..15.

Ports:
- clk  in  1  CPU clock; all inputs sampled on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- addr  in  12  CPU address bus.
- d_i  in  8  CPU data out; status flags on [7:4] during ads_n, write data during wr_n.
- ads_n  in  1  address strobe, active-low.
- rd_n  in  1  read strobe, active-low.
- wr_n  in  1  write strobe, active-low.
- d_o  out  8  read data to CPU.
- hold_n  out  1  cycle extend to CPU, active-low.
- flags  out  4  latched {H,D,I,R} from last address strobe.
- sel  out  1  latched: last captured address lies in the window.

Behaviour:
- Reset values: d_o=8'hFF, hold_n=1, flags=4'b0000, sel=0, FSM=IDLE. RAM contents are not reset.
- Window test: sel = ((addr & ~(MEM_SIZE-1)) == BASE_ADDR). RAM index = addr & (MEM_SIZE-1).
- FSM states: IDLE, ADDR, WAIT, DONE. All outputs are registered.
- IDLE: ads_n sampled low at edge N -> at N+1: addr_q=addr, flags=d_i[7:4], sel updated, state ADDR.
- ADDR: first edge M where rd_n xor wr_n is sampled low:
  - sel=0: state DONE; d_o stays FF; no write; hold_n stays 1.
  - sel=1, WAIT_STATES>0: hold_n=0 from M+1; wait counter loaded with WAIT_STATES-1; state WAIT.
  - sel=1, WAIT_STATES=0: access completes at M+1 (see completion).
- WAIT: counter decrements each edge; at the edge where counter==0, access completes, hold_n=1, state DONE. hold_n is low for exactly WAIT_STATES cycles.
- Completion, read: d_o = RAM[addr_q index], held until rd_n is sampled high.
- Completion, write: RAM[addr_q index] = d_i sampled at the completion edge.
- DONE: when rd_n and wr_n are both sampled high -> d_o=FF, state IDLE.
- Read latency: data valid at M+1+WAIT_STATES.
- rd_n and wr_n both low in ADDR: protocol error -> DONE, no write, d_o=FF, no hold.
- ads_n low in ADDR/WAIT/DONE: abort current access (hold_n=1, d_o=FF, no write), recapture addr/flags, state ADDR.
- Strobe released during WAIT: abort, no write, hold_n=1, state IDLE.
- rst_n low mid-access: immediate return to reset values; an in-progress write is discarded.
- Back-to-back cycles: IDLE is re-entered one edge after the strobes release; ads_n may then assert on the next edge.

Optional Feature:
- Macro: SCMP_BUS_RESP_WPROT_EN.
- Defined: the lower half of the window (index < MEM_SIZE/2) is read-only. Writes there complete normally (same hold_n timing) but RAM is unchanged. Intended for a preloaded boot image.
- Undefined: the entire window is writable.

Test Plan:
- Reset: rst_n low mid-WAIT -> d_o=FF, hold_n=1, flags=0 immediately, without waiting for a clock edge.
- Status capture: ads_n low with addr=12'h010, d_i=8'hA5 -> next edge flags=4'hA, sel=1; then rd_n low -> hold_n low for 1 cycle, d_o=RAM[16] at M+2.
- Write/readback with WAIT_STATES=3: write 8'h3C to 12'h07F -> hold_n low 3 cycles; read 12'h07F -> d_o=8'h3C.
- Unselected with BASE_ADDR=0: read 12'h080 -> sel=0, hold_n never low, d_o=FF; write 12'h080 -> RAM[0] unchanged.
- Abort: ads_n re-asserted during WAIT with addr=12'h020 -> no write to first address, new addr/flags captured, access proceeds for 12'h020.
- WPROT: with SCMP_BUS_RESP_WPROT_EN defined, write 8'h55 to 12'h005 -> readback shows original value; write 8'h55 to 12'h045 -> reads 8'h55. With macro undefined, both read 8'h55.
